// File: rtl/jts16_obj_pkg.sv
// Shared constants, pixel field layout and sequencer state type for the object line buffer.
package jts16_obj_pkg;

   localparam int AW       = 9;
   localparam int PRIO_MSB = 11;
   localparam int PAL_LSB  = 4;
   localparam int COL_MSB  = 3;
   localparam int DW       = PRIO_MSB + 1;
   localparam int PAL_MSB  = PRIO_MSB - 2;

   localparam logic [PAL_MSB:PAL_LSB] SHADOW_PAL = 6'h3F;

   typedef enum logic { CLEAR, RUN } state_t;

   function automatic logic is_shadow(input logic [PAL_MSB:PAL_LSB] pal);
      return pal == SHADOW_PAL;
   endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port RAM: registered read on port 0, write on port 1; a same-cycle read returns the old word.
module jtframe_dual_ram #(
   parameter int DW = 8,
   parameter int AW = 10
)(
   input  logic          clk,
   input  logic [AW-1:0] addr0,
   output logic [DW-1:0] q0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] data1,
   input  logic          we1
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      q0 <= mem[addr0];
      if (we1) mem[addr1] <= data1;
   end
endmodule

// File: rtl/jts16_obj_bank.sv
// One object line-buffer bank: port 0 reads (scan or RMW), port 1 writes (clear, erase or draw).
import jts16_obj_pkg::*;

module jts16_obj_bank #(
   parameter int AW = jts16_obj_pkg::AW,
   parameter int DW = jts16_obj_pkg::DW
)(
   input  logic          clk,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          wr_en
);
   jtframe_dual_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .addr0 (rd_addr),
      .q0    (rd_data),
      .addr1 (wr_addr),
      .data1 (wr_data),
      .we1   (wr_en)
   );
endmodule

// File: rtl/jts16_obj_buffer.sv
// Double-buffered object line buffer feeding the colour mixer; swaps banks on LHBL fall.
// Define JTS16_OBJ_FIRSTWIN_EN to make the first-drawn opaque pixel win over later ones.
import jts16_obj_pkg::*;

module jts16_obj_buffer #(
   parameter int AW = jts16_obj_pkg::AW,
   parameter int DW = jts16_obj_pkg::DW
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          pxl_cen,
   input  logic          LHBL,
   input  logic [AW-1:0] hdump,
   input  logic [AW-1:0] draw_addr,
   input  logic [DW-1:0] draw_data,
   input  logic          draw_we,
   output logic          draw_ready,
   output logic [DW-1:0] obj_pxl
);
   state_t        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic          run;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      draw_ready = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (&clr_addr_q) state_d = RUN;
         end
         RUN: draw_ready = 1'b1;
         default: state_d = CLEAR;
      endcase
   end

   assign run = (state_q == RUN);

   logic lhbl_q, bank_sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lhbl_q     <= 1'b0;
         bank_sel_q <= 1'b0;
      end else if (pxl_cen) begin
         lhbl_q <= LHBL;
         if (lhbl_q && !LHBL) bank_sel_q <= ~bank_sel_q;
      end
   end

   // Scan: read issued on one pxl_cen, loaded and erased on the next
   logic          rd_vis_q, rd_bank_q, scan_pend_q, erase_en;
   logic [AW-1:0] rd_addr_q;
   logic [DW-1:0] scan_hold_q, scan_word, obj_pxl_q;
   logic [DW-1:0] bank_q [2];

   // RAM output is only valid the clk after the read; hold it for slow pixel clocks
   assign scan_word = scan_pend_q ? bank_q[rd_bank_q] : scan_hold_q;
   assign erase_en  = pxl_cen && rd_vis_q;
   assign obj_pxl   = obj_pxl_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vis_q    <= 1'b0;
         scan_pend_q <= 1'b0;
         obj_pxl_q   <= '0;
      end else begin
         scan_pend_q <= pxl_cen;
         if (pxl_cen) begin
            rd_vis_q  <= LHBL && run;
            obj_pxl_q <= rd_vis_q ? scan_word : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (pxl_cen) begin
         rd_addr_q <= hdump;
         rd_bank_q <= bank_sel_q;
      end
      if (scan_pend_q) scan_hold_q <= bank_q[rd_bank_q];
   end

   // Draw RMW: stage 0 reads the tagged back bank, stage 1 writes it
   logic          s0_acc, s1_vld_q, s1_bank_q, s1_wr;
   logic [AW-1:0] s1_addr_q;
   logic [DW-1:0] s1_data_q;

   assign s0_acc = run && draw_we && (draw_data[COL_MSB:0] != '0);

   always_ff @(posedge clk) begin
      if (rst) s1_vld_q <= 1'b0;
      else     s1_vld_q <= s0_acc;
      s1_addr_q <= draw_addr;
      s1_data_q <= draw_data;
      s1_bank_q <= ~bank_sel_q;
   end

`ifdef JTS16_OBJ_FIRSTWIN_EN
   logic             fwd_hit_q;
   logic [COL_MSB:0] fwd_col_q, old_col;

   // The RAM read misses a write landing on the same edge, so forward it
   assign old_col = fwd_hit_q ? fwd_col_q : bank_q[s1_bank_q][COL_MSB:0];
   assign s1_wr   = s1_vld_q && (old_col == '0);

   always_ff @(posedge clk) begin
      if (rst) fwd_hit_q <= 1'b0;
      else     fwd_hit_q <= s0_acc && s1_wr && (s1_addr_q == draw_addr)
                            && (s1_bank_q == ~bank_sel_q);
      fwd_col_q <= s1_data_q[COL_MSB:0];
   end
`else
   assign s1_wr = s1_vld_q;
`endif

   for (genvar g = 0; g < 2; g++) begin : g_bank
      logic          is_front, erase_here, draw_here;
      logic [AW-1:0] rd_addr, wr_addr;
      logic [DW-1:0] wr_data;
      logic          wr_en;

      assign is_front   = (bank_sel_q == 1'(g));
      assign erase_here = erase_en && (rd_bank_q == 1'(g));
      assign draw_here  = s1_wr && (s1_bank_q == 1'(g));
      assign rd_addr    = is_front ? hdump : draw_addr;
      assign wr_en      = !run || erase_here || draw_here;
      assign wr_addr    = !run ? clr_addr_q : (erase_here ? rd_addr_q : s1_addr_q);
      assign wr_data    = (!run || erase_here) ? '0 : s1_data_q;

      jts16_obj_bank #(.AW(AW), .DW(DW)) u_bank (
         .clk     (clk),
         .rd_addr (rd_addr),
         .rd_data (bank_q[g]),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .wr_en   (wr_en)
      );
   end
endmodule

// File: tb/tb_jts16_obj_buffer.sv
// Bench for jts16_obj_buffer: directed table, hand sequences and random traffic vs a line-buffer model.
module tb_jts16_obj_buffer;
   localparam int AW = 9;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          rst, pxl_cen, LHBL, draw_we, draw_ready;
   logic [AW-1:0] hdump, draw_addr;
   logic [DW-1:0] draw_data, obj_pxl;

   always #5 clk = ~clk;

   jts16_obj_buffer #(.AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pxl_cen    (pxl_cen),
      .LHBL       (LHBL),
      .hdump      (hdump),
      .draw_addr  (draw_addr),
      .draw_data  (draw_data),
      .draw_we    (draw_we),
      .draw_ready (draw_ready),
      .obj_pxl    (obj_pxl)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: two banks of pixels plus the one outstanding scan read
   logic [DW-1:0] mem [2][512];
   logic          m_sel, m_lhbl, m_vis, m_bank;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic model_reset(input logic lhbl_now);
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 512; i++) mem[b][i] = '0;
      m_sel = 1'b0; m_lhbl = lhbl_now; m_vis = 1'b0;
   endtask

   task automatic model_draw(input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (d[3:0] != 4'd0) begin
`ifdef JTS16_OBJ_FIRSTWIN_EN
         if (mem[!m_sel][a][3:0] == 4'd0) mem[!m_sel][a] = d;
`else
         mem[!m_sel][a] = d;
`endif
      end
   endtask

   task automatic model_cen(input logic [AW-1:0] hd, output logic [DW-1:0] exp);
      exp = m_vis ? m_data : '0;
      if (m_vis) mem[m_bank][m_addr] = '0;
      m_data = mem[m_sel][hd];
      m_addr = hd; m_bank = m_sel; m_vis = LHBL;
      if (m_lhbl && !LHBL) m_sel = !m_sel;
      m_lhbl = LHBL;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input bit dr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit cn, input logic [AW-1:0] hd, output logic [DW-1:0] seen);
      logic [DW-1:0] exp;
      exp = '0;
      draw_we = dr; draw_addr = a; draw_data = d; pxl_cen = cn; hdump = hd;
      if (dr) model_draw(a, d);
      if (cn) model_cen(hd, exp);
      tick();
      draw_we = 1'b0; pxl_cen = 1'b0;
      seen = obj_pxl;
      if (cn) check("scan", obj_pxl, exp);
   endtask

   task automatic draw(input logic [AW-1:0] a, input logic [DW-1:0] d);
      logic [DW-1:0] s;
      step(1'b1, a, d, 1'b0, '0, s);
   endtask

   task automatic cen(input logic [AW-1:0] hd, output logic [DW-1:0] s);
      step(1'b0, '0, '0, 1'b1, hd, s);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [DW-1:0] pat(input int h);
      return {2'(h % 4), 6'(h + 8), 4'(h % 15 + 1)};
   endfunction

   typedef struct {
      string         name;
      logic [AW-1:0] a;
      logic [DW-1:0] d0;
      bit            two;
      logic [DW-1:0] d1;
      logic [DW-1:0] exp;
   } vec_t;

   vec_t          tbl [6];
   logic [DW-1:0] s;
   logic [AW-1:0] hd;
   int            n, errs;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{"draw_c35",  9'd20,  12'hC35, 1'b0, 12'h000, 12'hC35};
      tbl[1] = '{"transp",    9'd5,   12'h3F0, 1'b0, 12'h000, 12'h000};
`ifdef JTS16_OBJ_FIRSTWIN_EN
      tbl[2] = '{"same_addr", 9'd7,   12'h411, 1'b1, 12'h822, 12'h411};
`else
      tbl[2] = '{"same_addr", 9'd7,   12'h411, 1'b1, 12'h822, 12'h822};
`endif
      tbl[3] = '{"edge_511",  9'd511, 12'hFFF, 1'b0, 12'h000, 12'hFFF};
      tbl[4] = '{"transp2",   9'd100, 12'hA01, 1'b1, 12'hB00, 12'hA01};
      tbl[5] = '{"addr0",     9'd0,   12'h7C8, 1'b0, 12'h000, 12'h7C8};

      rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; hdump = '0;
      draw_addr = '0; draw_data = '0; draw_we = 1'b0;
      tick(); tick();
      check("rst_ready", draw_ready, 0);
      check("rst_pxl", obj_pxl, 0);

      rst = 1'b0; n = 0;
      while (!draw_ready && n < 2000) begin
         tick(); n++;
         if (n == 100) check("clear_pxl", obj_pxl, 0);
      end
      check("clear_len", n, 512);
      model_reset(1'b0);

      // Both banks must read back zero after the clear sequence
      errs = 0;
      for (int h = 0; h < 512; h++) begin cen(9'(h), s); if (h > 0 && s != 0) errs++; end
      LHBL = 1'b0; cen('0, s); LHBL = 1'b1;
      for (int h = 0; h < 512; h++) begin cen(9'(h), s); if (h > 0 && s != 0) errs++; end
      check("clear_zero", errs, 0);

      foreach (tbl[i]) begin
         LHBL = 1'b1; cen(9'd200, s);
         draw(tbl[i].a, tbl[i].d0);
         if (tbl[i].two) draw(tbl[i].a, tbl[i].d1);
         idle(3);
         LHBL = 1'b0; cen('0, s); LHBL = 1'b1;
         cen(tbl[i].a, s); cen(tbl[i].a + 9'd1, s);
         check(tbl[i].name, s, tbl[i].exp);
         LHBL = 1'b0; cen('0, s); LHBL = 1'b1; cen(9'd300, s);
         LHBL = 1'b0; cen('0, s); LHBL = 1'b1;
         cen(tbl[i].a, s); cen(tbl[i].a + 9'd1, s);
         check({tbl[i].name, "_erased"}, s, 0);
      end

      // Scanning with LHBL low must neither show nor erase the line
      LHBL = 1'b1; cen(9'd200, s);
      for (int h = 0; h < 16; h++) draw(9'(h), pat(h));
      idle(3);
      LHBL = 1'b0; errs = 0;
      for (int h = 0; h < 16; h++) begin cen(9'(h), s); if (s != 0) errs++; end
      check("lhbl_low_hidden", errs, 0);
      LHBL = 1'b1;
      for (int h = 0; h <= 16; h++) begin
         cen(9'(h), s);
         if (h > 0) check("after_rise", s, pat(h - 1));
      end

      for (int ln = 0; ln < 25; ln++) begin
         LHBL = 1'b1; hd = '0;
         cen(hd, s); hd++;
         for (int op = 0; op < 40; op++) begin
            logic          dr, cn;
            logic [DW-1:0] d;
            dr = 1'($urandom_range(0, 1));
            cn = ($urandom_range(0, 2) != 0);
            d  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) d[3:0] = 4'd0;
            step(dr, 9'($urandom_range(0, 23)), d, cn, hd, s);
            if (cn) hd++;
         end
         idle(3);
         LHBL = 1'b0;
         cen(hd, s); cen(9'd0, s); cen(9'd1, s);
      end

      // Reset in the middle of a line holding data in both banks
      LHBL = 1'b1; cen(9'd0, s);
      draw(9'd10, 12'h5A7); draw(9'd11, 12'h1B3); idle(3);
      LHBL = 1'b0; cen(9'd0, s); LHBL = 1'b1;
      draw(9'd12, 12'h2C9); cen(9'd1, s); cen(9'd2, s);
      rst = 1'b1; tick(); rst = 1'b0;
      errs = 0;
      for (int i = 1; i <= 512; i++) begin
         pxl_cen = i[0]; draw_we = (i > 100); draw_addr = 9'(i % 32); draw_data = 12'hFF1;
         tick();
         if (i < 512 && (draw_ready !== 1'b0 || obj_pxl !== '0)) errs++;
      end
      pxl_cen = 1'b0; draw_we = 1'b0;
      check("rst_clear_quiet", errs, 0);
      check("rst_ready_again", draw_ready, 1);
      model_reset(1'b1);
      errs = 0;
      for (int h = 0; h < 33; h++) begin cen(9'(h), s); if (h > 0 && s != 0) errs++; end
      LHBL = 1'b0; cen('0, s); LHBL = 1'b1;
      for (int h = 0; h < 33; h++) begin cen(9'(h), s); if (h > 0 && s != 0) errs++; end
      check("post_rst_zero", errs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/jts16_obj_buffer.md
Name: jts16_obj_buffer

Overview:
Double-buffered object line buffer that sits directly upstream of the colour mixer and produces its 12-bit object pixel input: priority in bits 11:10, palette in 9:4, colour index in 3:0. The object draw engine writes the next line into the back bank while the front bank is scanned out at pixel rate and erased behind the beam. Banks swap at each falling edge of LHBL. After reset, a clear sequencer wipes both banks before drawing is allowed.

Parameters:
AW, 9, line-buffer address width (512 pixels per bank)
DW, 12, pixel word width {prio[1:0], pal[5:0], col[3:0]}

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
pxl_cen  input  1  pixel clock enable
LHBL  input  1  horizontal blank, active-low; falling edge swaps banks
hdump  input  AW  horizontal scan position of the pixel being read
draw_addr  input  AW  back-bank write address from the object draw engine
draw_data  input  DW  pixel to write
draw_we  input  1  single-cycle write strobe, one pixel per clk
draw_ready  output  1  high when draw writes are accepted (clear done)
obj_pxl  output  DW  object pixel to the colour mixer

Behaviour:
Reset:
- Synchronous, active-high.
- bank_sel=0, obj_pxl=0, draw_ready=0. The FSM enters CLEAR with clr_addr=0.
- rst asserted mid-operation aborts everything and restarts CLEAR.

FSM CLEAR:
- Each clk writes 0 to address clr_addr in both banks, then increments clr_addr.
- On clr_addr wrap from 2^AW-1 to 0, goes to RUN. Exactly 512 clk.
- draw_we is ignored and obj_pxl is held at 0 throughout CLEAR.

FSM RUN:
- draw_ready=1. Stays in RUN until reset.

Bank swap:
- The LHBL falling edge is detected on clk with a registered LHBL sampled on pxl_cen.
- On that edge, bank_sel toggles on the same pxl_cen.
- Front bank = bank_sel; back bank = ~bank_sel.

Draw path (RMW pipeline):
- Stage 0: a draw_we with draw_data[3:0]!=0 is accepted. Transparent pixels (col==0) are dropped. The request is tagged with the current back bank and the existing word is read.
- Stage 1: the word is written to the tagged bank.
- Throughput is 1 write per clk. Back-to-back writes to the same address forward the stage-1 data into the stage-0 compare.
- If a bank swap occurs while a request is in flight, the request completes into its tagged bank (now the front bank). Draw-engine timing prevents this, but it must not corrupt other addresses.

Scan path:
- On each pxl_cen, the front bank is read at hdump.
- On the next pxl_cen, obj_pxl is loaded with that data if LHBL was high when the read was issued, otherwise with 0. Latency is one pxl_cen.
- On the same pxl_cen that loads obj_pxl, 0 is written to the read address in the front bank (erase-after-read), only if LHBL was high.
- hdump beyond the visible area is read and erased normally; there is no wrap special case.

Simultaneous events:
- Draw writes target the back bank and erase targets the front bank, so they never collide.
- Each bank is dual-port: port 0 serves the scan read or the RMW read; port 1 serves the erase, draw write or clear write. Bank selection per port is by mux.

Optional Feature:
Macro JTS16_OBJ_FIRSTWIN_EN.
- Defined: a stage-1 write is suppressed when the existing word (after forwarding) has col!=0. The first-drawn object wins.
- Undefined: the read result is ignored and the last write wins. The pipeline depth stays at 2 stages so timing and latency are identical in both builds.

Decomposition:
- Package jts16_obj_pkg holds:
  - constants AW=9 and DW=12;
  - field offsets PRIO_MSB=11, PAL_LSB=4, COL_MSB=3;
  - the shadow palette value 6'h3F;
  - the FSM state enum {CLEAR, RUN}.
- One natural sub-module, jts16_obj_bank: a single dual-port bank wrapper built on jtframe_dual_ram, instantiated twice.
- The swap, RMW and erase logic stays in the top level.

Test Plan:
- Reset, then count clk until draw_ready rises -> exactly 512 clk. Reading any address in either bank gives 0x000.
- Draw 0xC35 at address 20 into the back bank, swap (LHBL fall), scan with hdump=20 -> obj_pxl=0xC35 one pxl_cen later. The next line at hdump=20 reads 0x000 (erased).
- Draw 0x3F0 (col=0) at address 5 -> bank content stays 0x000 and obj_pxl=0x000 when scanned.
- Write 0x411 then 0x822 to address 7 on consecutive clk:
  - FIRSTWIN_EN defined -> 0x411 scanned;
  - undefined -> 0x822 scanned.
- With LHBL low, scan addresses 0..15 of a line containing data -> obj_pxl stays 0 and the data is still present after LHBL rises.
- Assert rst mid-line with data in both banks -> draw_ready=0 and obj_pxl=0 for 512 clk, after which all addresses read 0x000.
